feistel_seq_ctrl: RTL and testbench
===================================

FEISTEL_SEQ_CTRL -- requirements
Module: feistel_seq_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 8, meaning Feistel rounds per block (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, meaning round-index width (SHALL satisfy 2**CNT_W >= ROUNDS).
REQ-003 SHALL have parameter KEY_TMO, default 64, meaning max cycles waiting for keys_ready (0 = no timeout).
REQ-004 SHALL have parameter STREAM, default 0, meaning 1 enables back-to-back blocks without a start-low gap.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level request to process one block.
REQ-008 enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled on the load_d cycle.
REQ-009 keys_ready  in  1  key schedule valid.
REQ-010 abort  in  1  cancel current operation.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 load_d  out  1  one-cycle strobe: seed input register.
REQ-014 load_k  out  1  key-generation request.
REQ-015 round  out  1  advance datapath one round this cycle.
REQ-016 round_idx  out  CNT_W  current round number, 0..ROUNDS-1.
REQ-017 key_idx  out  CNT_W  subkey select: round_idx if dir=0, ROUNDS-1-round_idx if dir=1.
REQ-018 dir  out  1  enc_dec value latched at load_d.
REQ-019 output_sig  out  1  one-cycle strobe: latch output register.
REQ-020 out_valid  out  1  result held valid until accepted.
REQ-021 err_tmo  out  1  sticky key-wait timeout flag.
REQ-022 state  out  3  encoded FSM state for debug.

Function
REQ-023 States SHALL be IDLE=0, KWAIT=1, ROUND=2, LATCH=3, HOLD=4, WAIT=5; codes 6-7 SHALL go to IDLE next cycle with all strobes low.
REQ-024 IDLE: start&keys_ready -> assert load_d, go ROUND; start&!keys_ready -> assert load_k, go KWAIT; else stay.
REQ-025 KWAIT: busy, load_k high; keys_ready -> assert load_d, go ROUND; timeout counter increments each KWAIT cycle.
REQ-026 If KEY_TMO>0 and KWAIT lasts KEY_TMO cycles without keys_ready, SHALL set err_tmo and go WAIT.
REQ-027 err_tmo SHALL clear only on the cycle load_d or load_k is asserted from IDLE, or on rst.
REQ-028 load_d cycle SHALL clear round_idx to 0 and latch dir<=enc_dec.
REQ-029 ROUND: busy, round high every cycle; round_idx increments each ROUND cycle; at round_idx==ROUNDS-1 go LATCH and round_idx returns to 0.
REQ-030 LATCH: output_sig high exactly one cycle, go HOLD.
REQ-031 HOLD: out_valid high; out_ready low -> stay; out_ready high -> result consumed that cycle.
REQ-032 HOLD with out_ready: if STREAM=1 and start&keys_ready, assert load_d same cycle and go ROUND; else go WAIT.
REQ-033 WAIT: busy; start low -> IDLE; start high -> stay (no restart).
REQ-034 Latency: load_d at cycle T -> round high T+1..T+ROUNDS, output_sig at T+ROUNDS+1, out_valid from T+ROUNDS+2.
REQ-035 abort SHALL have priority over all conditions: in any non-IDLE state -> IDLE next cycle, load_d/round/output_sig suppressed that cycle, round_idx and timeout counter cleared, err_tmo unchanged.
REQ-036 abort in IDLE SHALL suppress load_d and load_k that cycle and keep IDLE.
REQ-037 keys_ready falling during ROUND SHALL NOT affect sequencing.
REQ-038 enc_dec changes after load_d SHALL NOT affect dir or key_idx until next load_d.
REQ-039 load_d, load_k, round, output_sig, out_valid, busy SHALL be combinational decodes of state and inputs as above; round_idx, dir, err_tmo, state SHALL be registered.

Reset
REQ-040 On rst high at a clock edge: state=IDLE, round_idx=0, dir=0, err_tmo=0, timeout counter=0; all strobes, busy and out_valid low the following cycle, regardless of state when asserted.

Verification
REQ-041 ROUNDS=8, keys_ready=1, start pulse, enc_dec=0 -> load_d at T, round T+1..T+8 with key_idx 0..7, output_sig T+9, out_valid T+10.
REQ-042 enc_dec=1 -> key_idx sequence 7,6,...,0; dir=1 held through HOLD.
REQ-043 keys_ready low, KEY_TMO=4 -> load_k high 4 KWAIT cycles, err_tmo=1, WAIT; start low -> IDLE; next start clears err_tmo.
REQ-044 out_ready low 5 cycles in HOLD -> out_valid held 5 cycles; STREAM=1, start high at accept -> load_d same cycle, next block with no idle gap.
REQ-045 abort at round_idx=3 -> IDLE next cycle, no output_sig; rst during HOLD -> out_valid low next cycle, state=0.

Source files
------------

// File: rtl/feistel_seq_ctrl.sv
// Sequencing controller for an iterated Feistel datapath: key wait, round stepping,
// output latch and result hand-off, with abort and key-wait timeout.
module feistel_seq_ctrl #(
    parameter int unsigned ROUNDS  = 8,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned KEY_TMO = 64,
    parameter bit          STREAM  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             enc_dec_i,
    input  logic             keys_ready_i,
    input  logic             abort_i,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             load_d_o,
    output logic             load_k_o,
    output logic             round_o,
    output logic [CNT_W-1:0] round_idx_o,
    output logic [CNT_W-1:0] key_idx_o,
    output logic             dir_o,
    output logic             output_sig_o,
    output logic             out_valid_o,
    output logic             err_tmo_o,
    output logic [2:0]       state_o
);

    localparam int unsigned TmoW = (KEY_TMO > 1) ? $clog2(KEY_TMO) : 1;
    localparam logic [TmoW-1:0]  TmoLast = (KEY_TMO > 0) ? TmoW'(KEY_TMO - 1) : '0;
    localparam logic [CNT_W-1:0] IdxLast = CNT_W'(ROUNDS - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StKwait = 3'd1,
        StRound = 3'd2,
        StLatch = 3'd3,
        StHold  = 3'd4,
        StWait  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] round_idx_q, round_idx_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             dir_q, dir_d;
    logic             err_tmo_q, err_tmo_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            round_idx_q <= '0;
            tmo_cnt_q   <= '0;
            dir_q       <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            dir_q       <= dir_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_idx_d  = round_idx_q;
        tmo_cnt_d    = '0;
        dir_d        = dir_q;
        err_tmo_d    = err_tmo_q;
        load_d_o     = 1'b0;
        load_k_o     = (state_q == StKwait);
        round_o      = 1'b0;
        output_sig_o = 1'b0;
        out_valid_o  = (state_q == StHold);
        busy_o       = (state_q != StIdle);

        if (abort_i && state_q != StIdle) begin
            // Abort wins over everything; err_tmo is deliberately left untouched.
            state_d     = StIdle;
            round_idx_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!abort_i && start_i) begin
                        err_tmo_d = 1'b0;
                        if (keys_ready_i) begin
                            load_d_o    = 1'b1;
                            round_idx_d = '0;
                            dir_d       = enc_dec_i;
                            state_d     = StRound;
                        end else begin
                            load_k_o = 1'b1;
                            state_d  = StKwait;
                        end
                    end
                end
                StKwait: begin
                    if (keys_ready_i) begin
                        load_d_o    = 1'b1;
                        round_idx_d = '0;
                        dir_d       = enc_dec_i;
                        state_d     = StRound;
                    end else if (KEY_TMO > 0 && tmo_cnt_q == TmoLast) begin
                        err_tmo_d = 1'b1;
                        state_d   = StWait;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                StRound: begin
                    round_o = 1'b1;
                    if (round_idx_q == IdxLast) begin
                        round_idx_d = '0;
                        state_d     = StLatch;
                    end else begin
                        round_idx_d = round_idx_q + 1'b1;
                    end
                end
                StLatch: begin
                    output_sig_o = 1'b1;
                    state_d      = StHold;
                end
                StHold: begin
                    if (out_ready_i) begin
                        if (STREAM && start_i && keys_ready_i) begin
                            load_d_o    = 1'b1;
                            round_idx_d = '0;
                            dir_d       = enc_dec_i;
                            state_d     = StRound;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (!start_i) state_d = StIdle;
                end
                default: begin
                    state_d  = StIdle;
                    load_k_o = 1'b0;
                end
            endcase
        end
    end

    assign round_idx_o = round_idx_q;
    assign key_idx_o   = dir_q ? (IdxLast - round_idx_q) : round_idx_q;
    assign dir_o       = dir_q;
    assign err_tmo_o   = err_tmo_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_feistel_seq_ctrl.sv
// Scoreboard bench for feistel_seq_ctrl: expected key_idx sequences and strobe cycles are
// queued when a block is launched and popped as the DUT produces rounds and outputs.
module tb_feistel_seq_ctrl;

    localparam int Rounds = 8;
    localparam int CntW   = 3;
    localparam int KeyTmo = 4;

    logic            clk = 1'b0;
    logic            rst, start, enc_dec, keys_ready, abort, out_ready;
    logic            busy, load_d, load_k, round, dir, output_sig, out_valid, err_tmo;
    logic [CntW-1:0] round_idx, key_idx;
    logic [2:0]      state;

    feistel_seq_ctrl #(
        .ROUNDS (Rounds),
        .CNT_W  (CntW),
        .KEY_TMO(KeyTmo),
        .STREAM (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .enc_dec_i   (enc_dec),
        .keys_ready_i(keys_ready),
        .abort_i     (abort),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .load_d_o    (load_d),
        .load_k_o    (load_k),
        .round_o     (round),
        .round_idx_o (round_idx),
        .key_idx_o   (key_idx),
        .dir_o       (dir),
        .output_sig_o(output_sig),
        .out_valid_o (out_valid),
        .err_tmo_o   (err_tmo),
        .state_o     (state)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   key_q[$];
    int   ot_q[$];
    int   ov_q[$];
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: consume expectations as the DUT emits rounds and result strobes.
    always @(negedge clk) begin
        if (round) begin
            if (key_q.size() == 0) check("round_unexpected", {31'b0, round}, 0);
            else check("key_idx", {29'b0, key_idx}, key_q.pop_front());
        end
        if (output_sig) begin
            if (ot_q.size() == 0) check("osig_unexpected", {31'b0, output_sig}, 0);
            else check("osig_cycle", cyc, ot_q.pop_front());
        end
        if (out_valid && !ov_prev) begin
            if (ov_q.size() == 0) check("ovalid_unexpected", {31'b0, out_valid}, 0);
            else check("ovalid_cycle", cyc, ov_q.pop_front());
        end
        ov_prev = out_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the load_d cycle's sample point.
    task automatic push_block(input logic enc, input int n_keys, input bit timing);
        for (int i = 0; i < n_keys; i++) key_q.push_back(enc ? Rounds - 1 - i : i);
        if (timing) begin
            ot_q.push_back(cyc + Rounds + 1);
            ov_q.push_back(cyc + Rounds + 2);
        end
    endtask

    task automatic start_block(input logic enc, input int n_keys, input bit timing);
        start   = 1'b1;
        enc_dec = enc;
        @(negedge clk);
        check("load_d", {31'b0, load_d}, 1);
        push_block(enc, n_keys, timing);
        tick();
        start   = 1'b0;
        enc_dec = ~enc;
    endtask

    task automatic wait_hold();
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("reach_hold", {31'b0, out_valid}, 1);
    endtask

    task automatic finish_block(input logic enc, input int hold);
        int held;
        held = 0;
        wait_hold();
        check("dir_hold", {31'b0, dir}, {31'b0, enc});
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (out_valid) held++;
            tick();
        end
        check("ovalid_held", held, hold);
        check("ovalid_still", {31'b0, out_valid}, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("state_wait", {29'b0, state}, 5);
        tick();
        check("state_idle", {29'b0, state}, 0);
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1; start = 1'b0; enc_dec = 1'b0; keys_ready = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", {29'b0, state}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ovalid", {31'b0, out_valid}, 0);
        check("rst_err", {31'b0, err_tmo}, 0);
        check("rst_idx", {29'b0, round_idx}, 0);
        check("rst_dir", {31'b0, dir}, 0);

        // Encrypt and decrypt blocks with key ready.
        keys_ready = 1'b1;
        start_block(1'b0, Rounds, 1'b1);
        finish_block(1'b0, 3);
        start_block(1'b1, Rounds, 1'b1);
        finish_block(1'b1, 5);

        // Abort in IDLE blocks the launch.
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_idle_load", {31'b0, load_d}, 0);
        tick();
        check("abort_idle_state", {29'b0, state}, 0);
        abort = 1'b0; start = 1'b0;
        tick();

        // Key-wait timeout.
        keys_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        check("load_k_idle", {31'b0, load_k}, 1);
        tick();
        n = 0; k = 0;
        while (state == 3'd1 && n < 20) begin
            if (load_k) k++;
            tick();
            n++;
        end
        check("kwait_cycles", k, KeyTmo);
        check("tmo_err", {31'b0, err_tmo}, 1);
        check("tmo_state", {29'b0, state}, 5);
        tick();
        tick();
        check("wait_stay", {29'b0, state}, 5);
        start = 1'b0;
        tick();
        check("wait_to_idle", {29'b0, state}, 0);
        check("err_sticky", {31'b0, err_tmo}, 1);
        start = 1'b1;
        @(negedge clk);
        check("load_k_again", {31'b0, load_k}, 1);
        tick();
        check("err_cleared", {31'b0, err_tmo}, 0);
        check("kwait_state", {29'b0, state}, 1);
        keys_ready = 1'b1;
        @(negedge clk);
        check("load_d_kwait", {31'b0, load_d}, 1);
        push_block(1'b0, Rounds, 1'b1);
        tick();
        start = 1'b0;
        finish_block(1'b0, 0);

        // Streaming: accept with start high relaunches in the same cycle.
        start_block(1'b0, Rounds, 1'b1);
        start = 1'b1;
        wait_hold();
        out_ready = 1'b1;
        enc_dec = 1'b1;
        @(negedge clk);
        check("stream_load", {31'b0, load_d}, 1);
        push_block(1'b1, Rounds, 1'b1);
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("stream_no_gap", {29'b0, state}, 2);
        finish_block(1'b1, 5);

        // Abort at round_idx 3: three rounds seen, no output strobe.
        start_block(1'b0, 3, 1'b0);
        n = 0;
        while (round_idx != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        check("abort_at_idx", {29'b0, round_idx}, 3);
        abort = 1'b1;
        @(negedge clk);
        check("abort_round", {31'b0, round}, 0);
        tick();
        abort = 1'b0;
        check("abort_state", {29'b0, state}, 0);
        check("abort_idx", {29'b0, round_idx}, 0);
        for (int i = 0; i < 12; i++) tick();

        // Reset while holding a result.
        start_block(1'b1, Rounds, 1'b1);
        wait_hold();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_hold_ovalid", {31'b0, out_valid}, 0);
        check("rst_hold_state", {29'b0, state}, 0);
        check("rst_hold_dir", {31'b0, dir}, 0);
        check("rst_hold_busy", {31'b0, busy}, 0);

        tick();
        tick();
        check("queues_empty", key_q.size() + ot_q.size() + ov_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
